// File: rtl/adder_vector_sequencer.sv
// Self-test sequencer for a DW-bit adder.
// Walks {a, b, expected} triples in a synchronous-read vector RAM, drives the
// adder operands, compares the full DW+1-bit sum against the expected word and
// counts mismatches. It reports busy/done/pass and a saturating error count.
module adder_vector_sequencer #(
  parameter int DW   = 4,
  parameter int AW   = 6,
  parameter int NVEC = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW:0]   mem_rdata,
  output logic [DW-1:0] add_a,
  output logic [DW-1:0] add_b,
  input  logic [DW:0]   add_sum,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_count,
  output logic [3:0]    vec_idx
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_B = 3'd2,
    S_FETCH_T = 3'd3,
    S_LATCH_T = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NVEC - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [DW:0]   t_q, t_d;
  logic [DW-1:0] add_a_q, add_a_d;
  logic [DW-1:0] add_b_q, add_b_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [3:0]    vec_idx_q, vec_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  // Read strobe and address decode straight from state and base pointer.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = {AW{1'b0}};
    case (state_q)
      S_FETCH_A: begin
        mem_rd   = 1'b1;
        mem_addr = base_q;
      end
      S_FETCH_B: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + AW'(1);
      end
      S_FETCH_T: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + AW'(2);
      end
      default: begin
        mem_rd   = 1'b0;
        mem_addr = {AW{1'b0}};
      end
    endcase
  end

  // Next-state, datapath captures and registered status outputs.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    t_d         = t_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    err_count_d = err_count_q;
    vec_idx_d   = vec_idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A run (or a restart from DONE) begins with fresh counters.
        if (start) begin
          state_d     = S_FETCH_A;
          base_d      = {AW{1'b0}};
          err_count_d = 8'd0;
          vec_idx_d   = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH_A: state_d = S_FETCH_B;
      S_FETCH_B: begin
        // Word a arrives one cycle after its read; its top bit is not an operand bit.
        add_a_d = mem_rdata[DW-1:0];
        state_d = S_FETCH_T;
      end
      S_FETCH_T: begin
        add_b_d = mem_rdata[DW-1:0];
        state_d = S_LATCH_T;
      end
      S_LATCH_T: begin
        // Expected value keeps all DW+1 bits so the carry-out gets checked.
        t_d     = mem_rdata;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if ((add_sum != t_q) && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end else begin
          err_count_d = err_count_q;
        end
        if (vec_idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          vec_idx_d = vec_idx_q + 4'd1;
          base_d    = base_q + AW'(3);
          state_d   = S_FETCH_A;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_count_d == 8'd0);
  end

  // State and output registers; reset aborts any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= {AW{1'b0}};
      t_q         <= {(DW+1){1'b0}};
      add_a_q     <= {DW{1'b0}};
      add_b_q     <= {DW{1'b0}};
      err_count_q <= 8'd0;
      vec_idx_q   <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      t_q         <= t_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      err_count_q <= err_count_d;
      vec_idx_q   <= vec_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign err_count = err_count_q;
  assign vec_idx   = vec_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_adder_vector_sequencer.sv
// Scoreboard bench for adder_vector_sequencer: a RAM model and adder model
// surround the DUT; stimulus pushes expected addresses and run results, a
// negedge monitor pops and compares them.
module tb_adder_vector_sequencer;
  localparam int DW = 4;
  localparam int AW = 6;
  localparam int NVEC = 15;

  typedef struct {
    int err;
    int pass;
    int vidx;
    int scyc;
  } run_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW:0]   mem_rdata = '0;
  logic [DW-1:0] add_a, add_b;
  logic [DW:0]   add_sum;
  logic          busy, done, pass;
  logic [7:0]    err_count;
  logic [3:0]    vec_idx;

  logic [DW:0] mem [0:(1<<AW)-1];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        done_prev = 1'b0;
  run_exp_t    exp_q[$];
  int          addr_q[$];

  adder_vector_sequencer #(.DW(DW), .AW(AW), .NVEC(NVEC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_idx(vec_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read vector RAM model.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=missing expected=present", name);
  endtask

  // Monitor: compares every read address and every completed run.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        if (addr_q.size() == 0) fail_now("addr_unexpected");
        else chk("mem_addr", int'(mem_addr), addr_q.pop_front());
      end else begin
        chk("addr_idle_zero", int'(mem_addr), 0);
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) fail_now("done_unexpected");
        else begin
          run_exp_t e;
          e = exp_q.pop_front();
          chk("err_count", int'(err_count), e.err);
          chk("pass", int'(pass), e.pass);
          chk("vec_idx", int'(vec_idx), e.vidx);
          chk("done_latency", cyc - e.scyc, 5 * NVEC);
          chk("busy_in_done", int'(busy), 0);
        end
      end
    end
    done_prev <= done;
  end

  task automatic load_base();
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int i = 0; i < NVEC; i++) begin
      mem[3*i]   = (DW+1)'(i);
      mem[3*i+1] = (DW+1)'(i);
      mem[3*i+2] = (DW+1)'(2*i);
    end
  endtask

  // Pulse start; record the sampling edge and queue the expected response.
  task automatic start_run(input int err, input int ps);
    run_exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.err = err; e.pass = ps; e.vidx = NVEC - 1; e.scyc = cyc;
    exp_q.push_back(e);
    for (int a = 0; a < 3 * NVEC; a++) addr_q.push_back(a);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 150);
    if (!done) fail_now("done_timeout");
    @(negedge clk);
  endtask

  initial begin
    load_base();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_vec", int'(vec_idx), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_add_a", int'(add_a), 0);
    rst = 1'b0;

    // Clean run over {i, i, 2i}.
    start_run(0, 1);
    wait_done();

    // Two corrupted expected words (vectors 3 and 7).
    mem[11] = 5'h1F; mem[23] = 5'h1F;
    start_run(2, 0);
    wait_done();
    load_base();

    // Carry-out compared: F+F = 1E passes, 0E fails.
    mem[0] = 5'h0F; mem[1] = 5'h0F; mem[2] = 5'h1E;
    start_run(0, 1);
    wait_done();
    mem[2] = 5'h0E;
    start_run(1, 0);
    wait_done();
    load_base();

    // Start while busy is ignored.
    start_run(0, 1);
    repeat (19) @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done();

    // Reset mid-run with one error already counted.
    mem[11] = 5'h1F; mem[23] = 5'h1F;
    start_run(2, 0);
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err_count), 0);
    chk("midrst_mem_rd", int'(mem_rd), 0);
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    load_base();
    start_run(0, 1);
    wait_done();

    // Errored run, then fix memory and restart from DONE.
    mem[11] = 5'h1F; mem[23] = 5'h1F;
    start_run(2, 0);
    wait_done();
    load_base();
    start_run(0, 1);
    chk("restart_err_clear", int'(err_count), 0);
    chk("restart_done_drop", int'(done), 0);
    chk("restart_pass_drop", int'(pass), 0);
    chk("restart_busy", int'(busy), 1);
    wait_done();

    chk("exp_q_drained", exp_q.size(), 0);
    chk("addr_q_drained", addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_vector_sequencer.md
Name: adder_vector_sequencer

Overview:
Hardware self-test sequencer for the DW-bit adder datapath (a+b -> DW+1-bit sum). It walks a vector memory holding triples {a, b, expected} at consecutive addresses 3i, 3i+1 and 3i+2. For each triple it drives the adder, compares the sum against the expected value, and counts mismatches. It sits between the vector RAM read port and the adder instance, and reports done, pass and error count to the top level.

Parameters:
DW, 4, adder operand width; sum and memory words are DW+1 bits
AW, 6, vector memory address width
NVEC, 15, number of vectors per run; 3*NVEC-1 must not exceed 2^AW-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE and DONE
mem_rd  output  1  memory read strobe
mem_addr  output  AW  memory read address
mem_rdata  input  DW+1  read data, valid the cycle after mem_rd (synchronous read)
add_a  output  DW  adder operand a (registered)
add_b  output  DW  adder operand b (registered)
add_sum  input  DW+1  adder result, combinational from add_a/add_b
busy  output  1  run in progress
done  output  1  run complete; held until next start
pass  output  1  high in DONE when err_count==0
err_count  output  8  mismatch count, saturates at 255
vec_idx  output  4  index of the current vector, 0..NVEC-1

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; base pointer 0; internal t_reg 0. Reset mid-run aborts with no partial flags.
- FSM states: IDLE, FETCH_A, FETCH_B, FETCH_T, LATCH_T, CHECK, DONE.
- IDLE: start=1 -> FETCH_A; clears err_count, vec_idx and base (base=0).
- FETCH_A: mem_rd=1, mem_addr=base -> FETCH_B.
- FETCH_B: mem_rd=1, mem_addr=base+1; add_a <= mem_rdata[DW-1:0] -> FETCH_T.
- FETCH_T: mem_rd=1, mem_addr=base+2; add_b <= mem_rdata[DW-1:0] -> LATCH_T.
- LATCH_T: mem_rd=0; t_reg <= mem_rdata (full DW+1 bits) -> CHECK.
- CHECK: if add_sum != t_reg, err_count <= err_count+1, saturating at 255.
  - If vec_idx==NVEC-1 -> DONE.
  - Otherwise vec_idx+1, base+3 (adder only, no multiplier) -> FETCH_A.
- Timing: 5 cycles per vector. With start sampled at edge k, done=1 after edge k+5*NVEC (k+75 at default).
- DONE: done=1, busy=0, pass=(err_count==0).
  - add_a, add_b, err_count and vec_idx hold their values.
  - start=1 -> restart: same clears as IDLE, done/pass drop next cycle.
- busy=1 in every state except IDLE and DONE. start while busy is ignored.
- mem_addr is 0 whenever mem_rd=0.
- Operand upper bit: mem_rdata[DW] is ignored for a and b. Expected value compare is full DW+1 bits, so carry-out is checked.
- Outputs are registered, except mem_rd and mem_addr, which decode from state and base.

Test Plan:
- Memory = triples {i, i, 2i} for i=0..14; pulse start -> mem_addr sequence 0,1,2,3,...,44; done rises 75 cycles after start edge; pass=1, err_count=0, vec_idx=14.
- Same memory with expected words at addr 11 (vector 3) and 23 (vector 7) set to 1F -> err_count=2, pass=0, done=1.
- Vector 0 = {F, F, 1E} -> no error. Vector 0 = {F, F, 0E} -> err_count=1, proving the carry bit is compared.
- Pulse start again at cycle 20 of a run -> ignored; address sequence unbroken; done still at cycle 75.
- Assert rst at cycle 30 -> immediately busy=0, done=0, err_count=0, mem_rd=0. Next start restarts at mem_addr=0.
- Run with 2 errors to DONE, correct the memory, pulse start -> err_count clears to 0; second run ends pass=1.
